// File: rtl/sap_cpu_param.sv
// Purpose: parameterised SAP-1 style accumulator CPU with a six-state one-hot ring sequencer.
// Latency: every instruction occupies exactly six clk cycles (T1..T6); HLT parks the sequencer after T4.
// Backpressure: none; run=0 lets the current instruction finish, then the sequencer idles until run=1.
// Ports: clk, clr (synchronous active-high reset), run (execute/pause),
//        mem_addr/mem_rdata (asynchronous-read memory, mem_addr = MAR),
//        mem_we/mem_wdata (STA write during T5, mem_wdata = ACC),
//        ring_state (one-hot T1..T6, zero when idle/halted), pc, acc, flag_z, flag_c,
//        out_data/out_valid (OUT port, one-cycle registered pulse), halted.
module sap_cpu_param #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          run,
    input  logic [DW-1:0] mem_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic [5:0]    ring_state,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] acc,
    output logic          flag_z,
    output logic          flag_c,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    output logic          halted
);

    // The opcode nibble and the operand field must not overlap.
    generate
        if (DW < AW + 4) begin : g_width_check
            $error("sap_cpu_param: DW must be at least AW+4");
        end
    endgenerate

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDI = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [5:0] S_IDLE = 6'b000000;
    localparam logic [5:0] S_T1   = 6'b000001;
    localparam logic [5:0] S_T2   = 6'b000010;
    localparam logic [5:0] S_T3   = 6'b000100;
    localparam logic [5:0] S_T4   = 6'b001000;
    localparam logic [5:0] S_T5   = 6'b010000;
    localparam logic [5:0] S_T6   = 6'b100000;

    logic [5:0]    ring_q;
    logic [5:0]    ring_d;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] mar_q;
    logic [3:0]    ir_op;
    logic [AW-1:0] ir_arg;
    logic [DW-1:0] acc_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] out_q;
    logic          z_q;
    logic          c_q;
    logic          ov_q;
    logic          halt_q;

    // Only the opcode and operand fields of IR are ever decoded, so only they are stored.
    logic [DW:0]   sum;
    logic [DW-1:0] diff;

    assign sum  = {1'b0, acc_q} + {1'b0, b_q};
    assign diff = acc_q - b_q;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            ring_q <= S_IDLE;
        end else begin
            ring_q <= ring_d;
        end
    end

    // Sequencer next state: run is only looked at in idle and T6.
    always_comb begin
        ring_d = S_IDLE;
        case (ring_q)
            S_IDLE:  ring_d = (run && !halt_q) ? S_T1 : S_IDLE;
            S_T1:    ring_d = S_T2;
            S_T2:    ring_d = S_T3;
            S_T3:    ring_d = S_T4;
            S_T4:    ring_d = (ir_op == OP_HLT) ? S_IDLE : S_T5;
            S_T5:    ring_d = S_T6;
            S_T6:    ring_d = run ? S_T1 : S_IDLE;
            default: ring_d = S_IDLE;
        endcase
    end

    // Sequencer outputs: the write strobe is decoded straight from the ring so
    // that a reset into idle drops it immediately.
    always_comb begin
        mem_we = 1'b0;
        if ((ring_q == S_T5) && (ir_op == OP_STA)) begin
            mem_we = 1'b1;
        end
    end

    // Datapath: each T-state performs only the transfers listed for it.
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_q   <= '0;
            mar_q  <= '0;
            ir_op  <= '0;
            ir_arg <= '0;
            acc_q  <= '0;
            b_q    <= '0;
            out_q  <= '0;
            z_q    <= 1'b0;
            c_q    <= 1'b0;
            ov_q   <= 1'b0;
            halt_q <= 1'b0;
        end else begin
            ov_q <= (ring_q == S_T4) && (ir_op == OP_OUT);
            case (ring_q)
                S_T1: mar_q <= pc_q;
                S_T2: pc_q  <= pc_q + AW'(1);
                S_T3: begin
                    ir_op  <= mem_rdata[DW-1:DW-4];
                    ir_arg <= mem_rdata[AW-1:0];
                end
                S_T4: begin
                    case (ir_op)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_q <= ir_arg;
                        OP_LDI: acc_q  <= {{(DW-AW){1'b0}}, ir_arg};
                        OP_JMP: pc_q   <= ir_arg;
                        OP_JZ:  if (z_q) pc_q <= ir_arg;
                        OP_JC:  if (c_q) pc_q <= ir_arg;
                        OP_OUT: out_q  <= acc_q;
                        OP_HLT: halt_q <= 1'b1;
                        default: ;
                    endcase
                end
                S_T5: begin
                    case (ir_op)
                        OP_LDA:         acc_q <= mem_rdata;
                        OP_ADD, OP_SUB: b_q   <= mem_rdata;
                        default: ;
                    endcase
                end
                S_T6: begin
                    case (ir_op)
                        OP_ADD: begin
                            {c_q, acc_q} <= sum;
                            z_q          <= (sum[DW-1:0] == '0);
                        end
                        OP_SUB: begin
                            acc_q <= diff;
                            c_q   <= (acc_q >= b_q); // not-borrow
                            z_q   <= (diff == '0);
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = mar_q;
    assign mem_wdata  = acc_q;
    assign ring_state = ring_q;
    assign pc         = pc_q;
    assign acc        = acc_q;
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign out_data   = out_q;
    assign out_valid  = ov_q;
    assign halted     = halt_q;

endmodule

// File: tb/tb_sap_cpu_param.sv
// Purpose: self-checking bench for sap_cpu_param (DW=8, AW=4) with a 16-word memory model.
// Latency: expectations for OUT pulses and memory writes are queued when a program is loaded.
// Backpressure: none; run/clr are driven directly from the test tasks.
module tb_sap_cpu_param;

    localparam int DW = 8;
    localparam int AW = 4;

    localparam logic [5:0] S_T1 = 6'b000001;
    localparam logic [5:0] S_T2 = 6'b000010;
    localparam logic [5:0] S_T4 = 6'b001000;
    localparam logic [5:0] S_T5 = 6'b010000;
    localparam logic [5:0] S_T6 = 6'b100000;

    logic          clk = 1'b0;
    logic          clr;
    logic          run;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [5:0]    ring_state;
    logic [AW-1:0] pc;
    logic [DW-1:0] acc;
    logic          flag_z;
    logic          flag_c;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          halted;

    logic [7:0]  mem [16];
    logic [7:0]  exp_out_q [$];
    logic [11:0] exp_wr_q [$];

    int passed = 0;
    int total = 0;
    int retired = 0;
    int base = 0;
    int we_cycles = 0;
    int out_pulses = 0;

    always #5 clk = ~clk;

    sap_cpu_param #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .clr        (clr),
        .run        (run),
        .mem_rdata  (mem_rdata),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .ring_state (ring_state),
        .pc         (pc),
        .acc        (acc),
        .flag_z     (flag_z),
        .flag_c     (flag_c),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .halted     (halted)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr] = mem_wdata;
        if (clr === 1'b0 && ring_state === S_T6) retired++;
    end

    // Scoreboard: every OUT pulse and every write cycle is matched against the queues.
    always @(negedge clk) begin : monitor
        logic [7:0]  e_out;
        logic [11:0] e_wr;
        if (out_valid === 1'b1) begin
            out_pulses++;
            total++;
            if (exp_out_q.size() == 0) begin
                $display("FAIL out_unexpected: got out_data=%0h, required no OUT pulse", out_data);
            end else begin
                e_out = exp_out_q.pop_front();
                if (out_data !== e_out) $display("FAIL out_data: got %0h, required %0h", out_data, e_out);
                else passed++;
            end
            total++;
            if (ring_state !== S_T5) $display("FAIL out_valid_phase: ring %b, required %b", ring_state, S_T5);
            else passed++;
        end
        if (mem_we === 1'b1) begin
            we_cycles++;
            total++;
            if (exp_wr_q.size() == 0) begin
                $display("FAIL wr_unexpected: got addr=%0h data=%0h, required no write", mem_addr, mem_wdata);
            end else begin
                e_wr = exp_wr_q.pop_front();
                if ({mem_addr, mem_wdata} !== e_wr) $display("FAIL wr_addr_data: got %0h, required %0h", {mem_addr, mem_wdata}, e_wr);
                else passed++;
            end
            total++;
            if (ring_state !== S_T5) $display("FAIL wr_phase: ring %b, required %b", ring_state, S_T5);
            else passed++;
        end
    end

    task automatic begin_reset();
        @(posedge clk); #1;
        clr = 1'b1;
        run = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    endtask

    task automatic release_run();
        @(posedge clk); #1;
        clr = 1'b0;
        run = 1'b1;
        base = retired;
    endtask

    task automatic wait_retired(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (retired >= base + n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_halted(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (halted === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        begin_reset();
        @(negedge clk);
        total++; if (ring_state !== 6'b0) $display("FAIL rst_ring: got %b, required 000000", ring_state); else passed++;
        total++; if (pc !== 4'h0) $display("FAIL rst_pc: got %0h, required 0", pc); else passed++;
        total++; if (acc !== 8'h00) $display("FAIL rst_acc: got %0h, required 0", acc); else passed++;
        total++; if (flag_z !== 1'b0) $display("FAIL rst_z: got %b, required 0", flag_z); else passed++;
        total++; if (flag_c !== 1'b0) $display("FAIL rst_c: got %b, required 0", flag_c); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %0h, required 0", out_data); else passed++;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", out_valid); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b, required 0", halted); else passed++;
        total++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b, required 0", mem_we); else passed++;
        total++; if (mem_addr !== 4'h0) $display("FAIL rst_mem_addr: got %0h, required 0", mem_addr); else passed++;
        // Out of reset with run low the sequencer must stay idle.
        @(posedge clk); #1;
        clr = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ring_state !== 6'b0) $display("FAIL idle_hold: got %b, required 000000", ring_state); else passed++;
        @(posedge clk); #1;
        run = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (ring_state !== S_T1) $display("FAIL first_t1: got %b, required %b", ring_state, S_T1); else passed++;
        @(negedge clk);
        total++; if (ring_state !== S_T2) $display("FAIL t1_to_t2: got %b, required %b", ring_state, S_T2); else passed++;
    endtask

    task automatic test_program();
        int p0;
        begin_reset();
        mem[0] = 8'h09; mem[1] = 8'h1A; mem[2] = 8'h2B; mem[3] = 8'hE0; mem[4] = 8'hF0;
        mem[9] = 8'h10; mem[10] = 8'h14; mem[11] = 8'h18;
        exp_out_q.push_back(8'h0C);
        p0 = out_pulses;
        release_run();
        @(posedge clk);
        @(negedge clk);
        total++; if (ring_state !== S_T1) $display("FAIL prog_first_t1: got %b, required %b", ring_state, S_T1); else passed++;
        repeat (29) @(negedge clk);
        total++; if (halted !== 1'b1) $display("FAIL prog_halted: got %b, required 1", halted); else passed++;
        total++; if (acc !== 8'h0C) $display("FAIL prog_acc: got %0h, required 0c", acc); else passed++;
        total++; if (out_data !== 8'h0C) $display("FAIL prog_out_data: got %0h, required 0c", out_data); else passed++;
        total++; if (flag_c !== 1'b1) $display("FAIL prog_c: got %b, required 1", flag_c); else passed++;
        total++; if (flag_z !== 1'b0) $display("FAIL prog_z: got %b, required 0", flag_z); else passed++;
        total++; if (pc !== 4'h5) $display("FAIL prog_pc: got %0h, required 5", pc); else passed++;
        total++; if (out_pulses - p0 !== 1) $display("FAIL prog_out_pulses: got %0d, required 1", out_pulses - p0); else passed++;
        // run stays high but a halted CPU must not move.
        repeat (4) @(negedge clk);
        total++; if (ring_state !== 6'b0) $display("FAIL halt_ring: got %b, required 000000", ring_state); else passed++;
        total++; if (pc !== 4'h5) $display("FAIL halt_pc: got %0h, required 5", pc); else passed++;
    endtask

    task automatic test_arith();
        bit ok;
        begin_reset();
        mem[0] = 8'h0E; mem[1] = 8'h1F; mem[2] = 8'hE0; mem[3] = 8'h2D;
        mem[4] = 8'hE0; mem[5] = 8'h2C; mem[6] = 8'hE0; mem[7] = 8'hF0;
        mem[12] = 8'h01; mem[13] = 8'h10; mem[14] = 8'hF0; mem[15] = 8'h20;
        exp_out_q.push_back(8'h10);
        exp_out_q.push_back(8'h00);
        exp_out_q.push_back(8'hFF);
        release_run();
        wait_retired(2, ok);
        total++; if (!ok) $display("FAIL arith_add_timeout: retired %0d, required 2", retired - base); else passed++;
        total++; if (acc !== 8'h10) $display("FAIL add_acc: got %0h, required 10", acc); else passed++;
        total++; if (flag_c !== 1'b1) $display("FAIL add_c: got %b, required 1", flag_c); else passed++;
        total++; if (flag_z !== 1'b0) $display("FAIL add_z: got %b, required 0", flag_z); else passed++;
        wait_retired(4, ok);
        total++; if (!ok) $display("FAIL arith_sub_timeout: retired %0d, required 4", retired - base); else passed++;
        total++; if (acc !== 8'h00) $display("FAIL sub_eq_acc: got %0h, required 00", acc); else passed++;
        total++; if (flag_z !== 1'b1) $display("FAIL sub_eq_z: got %b, required 1", flag_z); else passed++;
        total++; if (flag_c !== 1'b1) $display("FAIL sub_eq_c: got %b, required 1", flag_c); else passed++;
        wait_retired(5, ok);
        // The OUT just retired must not disturb the flags.
        total++; if (flag_z !== 1'b1) $display("FAIL out_keeps_z: got %b, required 1", flag_z); else passed++;
        wait_retired(6, ok);
        total++; if (!ok) $display("FAIL arith_borrow_timeout: retired %0d, required 6", retired - base); else passed++;
        total++; if (acc !== 8'hFF) $display("FAIL sub_borrow_acc: got %0h, required ff", acc); else passed++;
        total++; if (flag_c !== 1'b0) $display("FAIL sub_borrow_c: got %b, required 0", flag_c); else passed++;
        total++; if (flag_z !== 1'b0) $display("FAIL sub_borrow_z: got %b, required 0", flag_z); else passed++;
        wait_halted(ok);
        total++; if (!ok) $display("FAIL arith_halt_timeout: got halted=%b, required 1", halted); else passed++;
        total++; if (exp_out_q.size() != 0) $display("FAIL arith_out_left: got %0d pending, required 0", exp_out_q.size()); else passed++;
    endtask

    task automatic test_jumps();
        bit ok;
        begin_reset();
        mem[0] = 8'h45; mem[1] = 8'h2A; mem[2] = 8'h68; mem[8] = 8'h7B;
        mem[10] = 8'h05; mem[11] = 8'h41; mem[12] = 8'h1A; mem[13] = 8'h63;
        mem[14] = 8'h73; mem[15] = 8'hF0;
        release_run();
        wait_retired(2, ok);
        repeat (4) @(negedge clk);
        total++; if (ring_state !== S_T5) $display("FAIL jz_phase: got %b, required %b", ring_state, S_T5); else passed++;
        total++; if (pc !== 4'h8) $display("FAIL jz_taken_pc: got %0h, required 8", pc); else passed++;
        wait_retired(3, ok);
        repeat (4) @(negedge clk);
        total++; if (pc !== 4'hB) $display("FAIL jc_taken_pc: got %0h, required b", pc); else passed++;
        wait_retired(6, ok);
        total++; if ({flag_z, flag_c} !== 2'b00) $display("FAIL add_clears_flags: got %b, required 00", {flag_z, flag_c}); else passed++;
        repeat (4) @(negedge clk);
        total++; if (pc !== 4'hE) $display("FAIL jz_not_taken_pc: got %0h, required e", pc); else passed++;
        wait_retired(7, ok);
        repeat (4) @(negedge clk);
        total++; if (pc !== 4'hF) $display("FAIL jc_not_taken_pc: got %0h, required f", pc); else passed++;
        wait_halted(ok);
        total++; if (!ok) $display("FAIL jump_halt_timeout: got halted=%b, required 1", halted); else passed++;
        total++; if (acc !== 8'h06) $display("FAIL jump_acc: got %0h, required 06", acc); else passed++;
    endtask

    task automatic test_store();
        bit ok;
        int w0;
        begin_reset();
        mem[0] = 8'h0E; mem[1] = 8'h37; mem[2] = 8'h07; mem[3] = 8'hE0; mem[4] = 8'hF0;
        mem[14] = 8'h5A;
        exp_wr_q.push_back({4'h7, 8'h5A});
        exp_out_q.push_back(8'h5A);
        w0 = we_cycles;
        release_run();
        wait_halted(ok);
        total++; if (!ok) $display("FAIL sta_halt_timeout: got halted=%b, required 1", halted); else passed++;
        total++; if (we_cycles - w0 !== 1) $display("FAIL sta_we_cycles: got %0d, required 1", we_cycles - w0); else passed++;
        total++; if (mem[7] !== 8'h5A) $display("FAIL sta_mem: got %0h, required 5a", mem[7]); else passed++;
        total++; if (exp_wr_q.size() != 0) $display("FAIL sta_wr_left: got %0d pending, required 0", exp_wr_q.size()); else passed++;
        total++; if (exp_out_q.size() != 0) $display("FAIL sta_out_left: got %0d pending, required 0", exp_out_q.size()); else passed++;
    endtask

    task automatic test_wrap();
        bit ok;
        begin_reset();
        mem[0] = 8'h5F;
        mem[15] = 8'h80;
        release_run();
        wait_retired(2, ok);
        total++; if (!ok) $display("FAIL wrap_timeout: retired %0d, required 2", retired - base); else passed++;
        total++; if (pc !== 4'h0) $display("FAIL wrap_pc: got %0h, required 0", pc); else passed++;
        @(negedge clk);
        total++; if (mem_addr !== 4'h0) $display("FAIL wrap_fetch_addr: got %0h, required 0", mem_addr); else passed++;
        repeat (3) @(negedge clk);
        total++; if (pc !== 4'hF) $display("FAIL wrap_refetch_jmp: got %0h, required f", pc); else passed++;
        total++; if ({flag_z, flag_c, halted} !== 3'b000) $display("FAIL wrap_status: got %b, required 000", {flag_z, flag_c, halted}); else passed++;
    endtask

    task automatic test_pause();
        bit ok;
        begin_reset();
        mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'hE0; mem[3] = 8'h37; mem[7] = 8'h33;
        exp_out_q.push_back(8'h02);
        release_run();
        repeat (3) @(posedge clk);
        #1 run = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (ring_state !== 6'b0) $display("FAIL pause_idle: got %b, required 000000", ring_state); else passed++;
        total++; if (acc !== 8'h01) $display("FAIL pause_completed: got acc %0h, required 01", acc); else passed++;
        repeat (5) @(negedge clk);
        total++; if (ring_state !== 6'b0) $display("FAIL pause_hold: got %b, required 000000", ring_state); else passed++;
        total++; if (pc !== 4'h1) $display("FAIL pause_pc: got %0h, required 1", pc); else passed++;
        @(posedge clk); #1;
        run = 1'b1;
        base = retired - 1;
        @(posedge clk);
        @(negedge clk);
        total++; if (ring_state !== S_T1) $display("FAIL resume_t1: got %b, required %b", ring_state, S_T1); else passed++;
        total++; if (pc !== 4'h1) $display("FAIL resume_pc: got %0h, required 1", pc); else passed++;
        wait_retired(3, ok);
        total++; if (!ok) $display("FAIL resume_timeout: retired %0d, required 3", retired - base); else passed++;
        repeat (3) @(negedge clk);
        total++; if (ring_state !== S_T4) $display("FAIL sta_t4: got %b, required %b", ring_state, S_T4); else passed++;
        clr = 1'b1;
        @(negedge clk);
        total++; if (ring_state !== 6'b0) $display("FAIL clr_ring: got %b, required 000000", ring_state); else passed++;
        total++; if (pc !== 4'h0) $display("FAIL clr_pc: got %0h, required 0", pc); else passed++;
        total++; if (acc !== 8'h00) $display("FAIL clr_acc: got %0h, required 00", acc); else passed++;
        total++; if (out_data !== 8'h00) $display("FAIL clr_out_data: got %0h, required 00", out_data); else passed++;
        total++; if (mem_addr !== 4'h0) $display("FAIL clr_mem_addr: got %0h, required 0", mem_addr); else passed++;
        total++; if ({mem_we, out_valid, halted, flag_z, flag_c} !== 5'b0) $display("FAIL clr_status: got %b, required 00000", {mem_we, out_valid, halted, flag_z, flag_c}); else passed++;
        repeat (3) @(negedge clk);
        total++; if (mem[7] !== 8'h33) $display("FAIL clr_no_write: got %0h, required 33", mem[7]); else passed++;
        total++; if (exp_out_q.size() != 0) $display("FAIL pause_out_left: got %0d pending, required 0", exp_out_q.size()); else passed++;
    endtask

    initial begin
        clr = 1'b1;
        run = 1'b0;
        test_reset();
        test_program();
        test_arith();
        test_jumps();
        test_store();
        test_wrap();
        test_pause();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
